// File: rtl/cnt69_pkg.sv
// Shared types and widths for the 74LS69-style ripple counter sequencer.
package cnt69_pkg;
  localparam int CNT_W  = 4;
  localparam int WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FALL,
    ST_RISE,
    ST_SETTLE,
    ST_CHECK
  } state_t;
endpackage

// File: rtl/cnt69_wait.sv
// Loadable down-counter with a zero flag; times the ripple-settle interval.
module cnt69_wait
  import cnt69_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_val,
  input  logic              i_dec,
  output logic              o_zero
);
  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cnt69_ctrl.sv
// Sequencer that clears a 4-bit ripple counter, issues N pulses and verifies it.
// Optional compare path (SETTLE/CHECK states) enabled by `define CNT69_CHECK_EN.
module cnt69_ctrl
  import cnt69_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic             qa,
  input  logic             qb,
  input  logic             qc,
  input  logic             qd,
  output logic             cclk,
  output logic             cclr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] q_cap
);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_n, r_p;
  logic             r_cclk, r_cclr, r_busy, r_done;
  logic             w_done;
  logic             w_last;

  assign w_last = (r_state == ST_CLEAR) ? (r_n == '0) : (r_p == r_n);

`ifdef CNT69_CHECK_EN
  logic             w_load, w_dec, w_zero;
  logic             r_err;
  logic [CNT_W-1:0] r_qcap;

  cnt69_wait u_wait (
    .clk    (clk),
    .rst_n  (clr),
    .i_load (w_load),
    .i_val  (WAIT_W'(SETTLE - 1)),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );
`else
  logic w_unused_q;
  assign w_unused_q = ^{qa, qb, qc, qd};
`endif

  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
`ifdef CNT69_CHECK_EN
    w_load = 1'b0;
    w_dec  = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE:  if (start) w_nxt = ST_CLEAR;
      ST_FALL:  w_nxt = ST_RISE;
      ST_CLEAR, ST_RISE: begin
        if (w_last) begin
`ifdef CNT69_CHECK_EN
          w_nxt  = ST_SETTLE;
          w_load = 1'b1;
`else
          // No compare stage: finish straight from the last pulse.
          w_nxt  = ST_IDLE;
          w_done = 1'b1;
`endif
        end else begin
          w_nxt = ST_FALL;
        end
      end
`ifdef CNT69_CHECK_EN
      ST_SETTLE: begin
        if (w_zero) begin
          w_nxt  = ST_CHECK;
          w_done = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_CHECK: w_nxt = ST_IDLE;
`endif
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_p     <= '0;
      r_cclk  <= 1'b1;
      r_cclr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cclk  <= (w_nxt != ST_FALL);
      r_cclr  <= (w_nxt != ST_CLEAR);
      r_busy  <= (w_nxt != ST_IDLE);
      r_done  <= w_done;
      if (r_state == ST_IDLE && start) r_n <= n;
      if (r_state == ST_CLEAR)         r_p <= '0;
      else if (r_state == ST_FALL)     r_p <= r_p + 1'b1;
    end
  end

`ifdef CNT69_CHECK_EN
  // Capture on entry to CHECK so q_cap/err are valid alongside done.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_err  <= 1'b0;
      r_qcap <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_err  <= 1'b0;
      r_qcap <= '0;
    end else if (r_state == ST_SETTLE && w_nxt == ST_CHECK) begin
      r_qcap <= {qd, qc, qb, qa};
      r_err  <= ({qd, qc, qb, qa} != r_n);
    end
  end

  assign err   = r_err;
  assign q_cap = r_qcap;
`else
  assign err   = 1'b0;
  assign q_cap = '0;
`endif

  assign cclk = r_cclk;
  assign cclr = r_cclr;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_cnt69_ctrl.sv
// Self-checking bench for cnt69_ctrl with a behavioural 4-bit ripple counter.
`timescale 1ns/1ps
module tb_cnt69_ctrl;
  localparam int SET = 4;
`ifdef CNT69_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0, clr = 1'b0, start = 1'b0;
  logic [3:0] n = 4'd0;
  logic       qa, qb, qc, qd;
  logic       cclk, cclr, busy, done, err;
  logic [3:0] q_cap;
  logic [3:0] cnt;
  logic       fqc = 1'b0;
  int         checks = 0, failures = 0;

  cnt69_ctrl #(.SETTLE(SET)) dut (
    .clk(clk), .clr(clr), .start(start), .n(n),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd),
    .cclk(cclk), .cclr(cclr), .busy(busy), .done(done),
    .err(err), .q_cap(q_cap)
  );

  always #5 clk = ~clk;

  // Counter model: advances on falling cclk, async clear on low cclr.
  always @(negedge cclk or negedge cclr) begin
    if (!cclr) cnt <= 4'd0;
    else       cnt <= #2 cnt + 4'd1;
  end
  assign {qd, qc, qb, qa} = {cnt[3], cnt[2] & ~fqc, cnt[1], cnt[0]};

  typedef struct { logic [3:0] q; logic e; int lat; int edges; } exp_t;
  typedef struct { logic [3:0] n; bit fqc; bit poke; logic [3:0] eq; logic ee; } vec_t;
  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e, g;
    int c, edges, lows, dones;
    int done_c;
    bit prev;
    @(negedge clk);
    n = v.n; fqc = v.fqc; start = 1'b1;
    e.q     = CHK ? v.eq : 4'd0;
    e.e     = CHK ? v.ee : 1'b0;
    e.lat   = CHK ? 2 * int'(v.n) + SET + 2 : 2 * int'(v.n) + 2;
    e.edges = int'(v.n);
    sb.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    edges = 0; lows = 0; done_c = 0; c = 0; prev = 1'b1;
    while (done_c == 0 && c < 200) begin
      @(negedge clk); c++;
      if (c == 1) begin
        chk("start_busy", busy, 1);
        chk("start_cclr", cclr, 0);
        chk("start_err_clr", err, 0);
        chk("start_qcap_clr", q_cap, 0);
      end
      if (prev && !cclk) edges++;
      prev = cclk;
      if (!cclr) lows++;
      if (v.poke && c == 2) begin
        chk("poke_in_fall", cclk, 0);
        start = 1'b1; n = 4'd9;
      end else if (v.poke && c == 3) begin
        start = 1'b0;
      end
      if (done) done_c = c;
    end
    g = sb.pop_front();
    if (done_c == 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", done_c, g.lat);
      chk("q_cap", q_cap, g.q);
      chk("err", err, g.e);
      chk("cclk_edges", edges, g.edges);
      chk("cclr_lows", lows, 1);
    end
    if (v.poke) begin
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      chk("poke_no_retrigger", dones, 0);
      chk("poke_idle", busy, 0);
    end
    if (v.ee && CHK) begin
      repeat (5) @(negedge clk);
      chk("err_hold", err, 1);
      chk("qcap_hold", q_cap, v.eq);
    end
    @(negedge clk);
  endtask

  initial begin
    int dones;
    //          n      fqc   poke  exp_q  exp_err
    vecs[0] = '{4'd5,  1'b0, 1'b0, 4'd5,  1'b0};
    vecs[1] = '{4'd0,  1'b0, 1'b0, 4'd0,  1'b0};
    vecs[2] = '{4'd15, 1'b0, 1'b0, 4'd15, 1'b0};
    vecs[3] = '{4'd1,  1'b0, 1'b0, 4'd1,  1'b0};
    vecs[4] = '{4'd6,  1'b1, 1'b0, 4'd2,  1'b1};
    vecs[5] = '{4'd3,  1'b0, 1'b1, 4'd3,  1'b0};
    vecs[6] = '{4'd10, 1'b0, 1'b0, 4'd10, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_cclk", cclk, 1);
    chk("rst_cclr", cclr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_qcap", q_cap, 0);
    chk("rst_cnt", cnt, 0);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cclr", cclr, 1);

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Asynchronous reset mid-run (inside SETTLE when the compare path exists).
    @(negedge clk);
    n = 4'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (CHK ? 2 * 4 + 3 : 5) @(negedge clk);
    chk("pre_clr_busy", busy, 1);
    #1 clr = 1'b0;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_cclr", cclr, 0);
    chk("clr_cclk", cclk, 1);
    chk("clr_done", done, 0);
    dones = 0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("clr_no_done", dones, 0);
    chk("clr_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=1 expected=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cnt69_ctrl.md
# cnt69_ctrl

Sequencer for a 4-bit negative-edge ripple counter of the 74LS69 family (single-clock, full-binary configuration). On a start request it clears the counter, issues exactly N count pulses, waits a programmable settle time to absorb ripple delay, then samples the counter outputs and flags any mismatch. It sits between bench or system logic and the counter model, owning the counter's clock and clear pins.

## Interface
- `SETTLE`, default 4: clk cycles between the last count pulse and the sample; legal range 1..255.
- `clk` input 1: controller clock; all state changes on its rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `start` input 1: request a run; sampled only in IDLE.
- `n` input 4: number of count pulses for the run; latched on accepted `start`.
- `qa`, `qb`, `qc`, `qd` input 1 each: counter outputs, `qa` is the LSB.
- `cclk` output 1: counter clock; the counter advances on its falling edge.
- `cclr` output 1: counter clear, active-low.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: single-cycle pulse at end of run.
- `err` output 1: result of the last compare; held until the next accepted `start`.
- `q_cap` output 4: counter value captured at the last compare; held until the next accepted `start`.

## Operation
- All outputs are registered.
- Reset values: `cclk`=1, `cclr`=0, `busy`=0, `done`=0, `err`=0, `q_cap`=0. Holding `cclr` low during reset clears the counter.
- States:
  - IDLE: `cclk`=1, `cclr`=1.
    - `start`=1 → latch `n` into `n_r`, clear `err` and `q_cap`, go to CLEAR.
  - CLEAR: `cclr`=0 for one cycle. Reset the pulse counter `p`=0.
    - `n_r`=0 → go to SETTLE.
    - Otherwise → go to FALL.
  - FALL: `cclk`=0 for one cycle; this produces the counting edge. Increment `p`. Go to RISE.
  - RISE: `cclk`=1 for one cycle.
    - `p`==`n_r` → go to SETTLE, load the wait timer with `SETTLE`-1.
    - Otherwise → go to FALL.
  - SETTLE: decrement the wait timer. At 0 → go to CHECK.
  - CHECK:
    - `q_cap` = {`qd`,`qc`,`qb`,`qa`}.
    - `err` = (`q_cap` != `n_r`).
    - `done`=1 for this cycle.
    - Go to IDLE.
- Comparison is 4-bit. The counter wraps at 16, so `n_r` is always representable.
- `start` outside IDLE is ignored and not queued. `start` held high re-triggers a new run on the cycle after CHECK.
- `n` changing after it is latched has no effect on the current run.
- `clr` low at any point: asynchronous return to IDLE with reset output values. Any partial run is discarded; no `done` is produced.

## Timing
- Accepted `start` at edge k:
  - CLEAR occupies cycle k+1.
  - Falling `cclk` edges occur at edges k+2, k+4, …, k+2n.
  - `done` is high in cycle k+2n+2+SETTLE.
- Total latency: 2n+SETTLE+2 cycles. For `n`=0: CLEAR, then SETTLE, then CHECK, giving SETTLE+2 cycles.
- `busy` rises with CLEAR and falls with the cycle after CHECK.
- Back-to-back runs: minimum one IDLE cycle between a `done` pulse and the next CLEAR.
- `cclk` pulse width is one clk period low and one clk period high. The counter's ripple delay must be shorter than SETTLE clk periods; the integrator sets SETTLE accordingly.

## Configuration
- `CNT69_CHECK_EN` defined:
  - Behaviour as above, including SETTLE and CHECK.
- `CNT69_CHECK_EN` undefined:
  - SETTLE and CHECK are compiled out; `q*` inputs are unused.
  - RISE with `p`==`n_r`, or CLEAR with `n_r`=0, goes directly to IDLE and asserts `done` in that transition cycle.
  - Latency is 2n+2 cycles.
  - `err` and `q_cap` are tied to 0.

## Structure
- Package `cnt69_pkg` holds:
  - the state enum (IDLE, CLEAR, FALL, RISE, SETTLE, CHECK);
  - the counter-width constant `CNT_W`=4;
  - the timer-width constant `WAIT_W`=8.
- One sub-module, `cnt69_wait`: a loadable down-counter with a `zero` flag, used for the SETTLE interval.

## Test plan
- Reset, release, then `start` with `n`=5, SETTLE=4, counter connected → 5 falling `cclk` edges, `done` 16 cycles after start, `q_cap`=5, `err`=0.
- `n`=0 → no `cclk` edges, one `cclr` low cycle, `done` after 6 cycles, `q_cap`=0, `err`=0.
- `n`=15 run followed by an `n`=1 run → `q_cap`=15, then `q_cap`=1, showing the second CLEAR removed the old count.
- Counter `qc` forced to 0, `n`=6 → `q_cap`=2, `err`=1, and `err` holds until the next `start`.
- `start` pulsed during FALL of an `n`=3 run, and `n` changed to 9 mid-run → exactly 3 edges, a single `done`, `q_cap`=3.
- `clr` asserted during SETTLE → `busy`=0, `cclr`=0, `cclk`=1 immediately, and no `done` pulse.
